// File: rtl/fxp_pkg.sv
// fxp_pkg: state encoding and signed-limit helpers shared by the fixed-point multiplier and divider.
package fxp_pkg;

   typedef enum logic [1:0] {IDLE, CALC, ROUND, SIGN} fxp_state_e;

   function automatic logic signed [63:0] fxp_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] fxp_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat: round-half-even of the magnitude product, overflow check and sign restore.
// Define FXP_MUL_SAT_EN to saturate on overflow; otherwise the result wraps.
module fxp_round_sat
   import fxp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FBITS = 12
) (
   input  logic [2*WIDTH-1:0] i_prod,
   input  logic               i_sdiff,
   output logic [WIDTH-1:0]   o_val,
   output logic               o_ovf
);

   localparam int PW = 2 * WIDTH;
   // Guard mask is empty when FBITS==0, which also disables the rounding increment
   localparam logic [PW-1:0] G_MASK = (PW'(1) << FBITS) >> 1;
   localparam logic [PW-1:0] LIM_P  = PW'(fxp_max(WIDTH));
   localparam logic [PW-1:0] LIM_N  = PW'(-fxp_min(WIDTH));

   logic [PW-1:0] w_q;
   logic [PW-1:0] w_qr;
   logic          w_guard;
   logic          w_sticky;

   always_comb begin
      w_q      = i_prod >> FBITS;
      w_guard  = |(i_prod & G_MASK);
      w_sticky = |(i_prod & (G_MASK - PW'(1)));
      w_qr     = w_q + PW'(w_guard & (w_sticky | w_q[0]));
      o_ovf    = w_qr > (i_sdiff ? LIM_N : LIM_P);
`ifdef FXP_MUL_SAT_EN
      o_val    = o_ovf ? (i_sdiff ? WIDTH'(fxp_min(WIDTH)) : WIDTH'(fxp_max(WIDTH)))
                       : (i_sdiff ? -w_qr[WIDTH-1:0] : w_qr[WIDTH-1:0]);
`else
      o_val    = i_sdiff ? -w_qr[WIDTH-1:0] : w_qr[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/fxp_seq_mul.sv
// fxp_seq_mul: sequential signed fixed-point multiplier, start/done handshake, WIDTH+2 cycle latency.
// Overflow behaviour selected by FXP_MUL_SAT_EN (saturate) vs. default wrap, inside fxp_round_sat.
module fxp_seq_mul
   import fxp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FBITS = 12
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [WIDTH-1:0] val
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   fxp_state_e         r_state;
   fxp_state_e         w_next;
   logic [WIDTH-1:0]   r_au;
   logic [WIDTH-1:0]   r_bu;
   logic               r_sdiff;
   logic [2*WIDTH-1:0] r_prod;
   logic [CW-1:0]      r_i;
   logic [WIDTH-1:0]   w_val;
   logic               w_ovf;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? CALC : IDLE;
         CALC:    w_next = (r_i == CW'(WIDTH - 1)) ? ROUND : CALC;
         ROUND:   w_next = SIGN;
         default: w_next = IDLE;
      endcase
   end

   // Magnitudes are WIDTH-bit unsigned so the most negative operand stays exact
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_au    <= '0;
         r_bu    <= '0;
         r_sdiff <= 1'b0;
         r_prod  <= '0;
         r_i     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         val     <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_au    <= a[WIDTH-1] ? -a : a;
               r_bu    <= b[WIDTH-1] ? -b : b;
               r_sdiff <= a[WIDTH-1] ^ b[WIDTH-1];
               r_prod  <= '0;
               r_i     <= '0;
               busy    <= 1'b1;
            end
            CALC: begin
               if (r_bu[r_i]) r_prod <= r_prod + ({{WIDTH{1'b0}}, r_au} << r_i);
               r_i <= r_i + CW'(1);
            end
            SIGN: begin
               val  <= w_val;
               ovf  <= w_ovf;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   fxp_round_sat #(.WIDTH(WIDTH), .FBITS(FBITS)) u_round_sat (
      .i_prod  (r_prod),
      .i_sdiff (r_sdiff),
      .o_val   (w_val),
      .o_ovf   (w_ovf)
   );

endmodule

// File: tb/tb_fxp_seq_mul.sv
// tb_fxp_seq_mul: table vectors, randomized ops against an integer reference, handshake corner cases.
module tb_fxp_seq_mul;

   localparam int W = 16;
   localparam int F = 12;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] v;
      logic         o;
      string        nm;
   } vec_t;

   logic         clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic         ovf;
   logic [W-1:0] val;

   int checks = 0;
   int failures = 0;

   fxp_seq_mul #(.WIDTH(W), .FBITS(F)) dut (
      .clk(clk), .i_rst_n(i_rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .ovf(ovf), .val(val)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Exact signed product, then round-half-even of |p| / 2^F using integer division arithmetic
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 output logic [W-1:0] v, output logic o);
      longint p, m, q, r, half, lim;
      bit neg;
      p    = longint'($signed(ma)) * longint'($signed(mb));
      neg  = p < 0;
      m    = neg ? -p : p;
      q    = m / (longint'(1) << F);
      r    = m - q * (longint'(1) << F);
      half = longint'(1) << (F - 1);
      if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
      lim  = neg ? 32768 : 32767;
      o    = q > lim;
`ifdef FXP_MUL_SAT_EN
      v = o ? (neg ? 16'h8000 : 16'h7FFF) : 16'(neg ? -q : q);
`else
      v = 16'(neg ? -q : q);
`endif
   endfunction

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!done && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   // Called #1 after a clock edge; returns #1 after the edge that raised done
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] v, output logic o, output int cnt);
      a = ia;
      b = ib;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      chk("busy_after_start", busy, 1);
      chk("done_is_pulse", done, 0);
      wait_done(cnt);
      v = val;
      o = ovf;
   endtask

   initial begin
      vec_t         tbl[$];
      logic [W-1:0] v, ev, ra, rb;
      logic         o, eo;
      int           cnt, seen;

      tbl.push_back('{16'h1800, 16'h2000, 16'h3000, 1'b0, "pos_1p5x2"});
      tbl.push_back('{16'hE800, 16'h2000, 16'hD000, 1'b0, "neg_1p5x2"});
      tbl.push_back('{16'h8000, 16'h1000, 16'h8000, 1'b0, "min_x1"});
      tbl.push_back('{16'h0001, 16'h0800, 16'h0000, 1'b0, "tie_even_down"});
      tbl.push_back('{16'h0003, 16'h0800, 16'h0002, 1'b0, "tie_even_up"});
      tbl.push_back('{16'hFFFD, 16'h0800, 16'hFFFE, 1'b0, "neg_tie"});
      tbl.push_back('{16'h0000, 16'hF000, 16'h0000, 1'b0, "zero_neg"});
      tbl.push_back('{16'hFFFF, 16'h0001, 16'h0000, 1'b0, "neg_to_zero"});
      tbl.push_back('{16'h7FFF, 16'h1000, 16'h7FFF, 1'b0, "max_x1"});
`ifdef FXP_MUL_SAT_EN
      tbl.push_back('{16'h3000, 16'h3000, 16'h7FFF, 1'b1, "ovf_9"});
      tbl.push_back('{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "ovf_max_sq"});
      tbl.push_back('{16'h8000, 16'h8000, 16'h7FFF, 1'b1, "ovf_min_sq"});
      tbl.push_back('{16'h8000, 16'hF000, 16'h7FFF, 1'b1, "ovf_min_xneg1"});
`else
      tbl.push_back('{16'h3000, 16'h3000, 16'h9000, 1'b1, "ovf_9"});
      tbl.push_back('{16'h7FFF, 16'h7FFF, 16'hFFF0, 1'b1, "ovf_max_sq"});
      tbl.push_back('{16'h8000, 16'h8000, 16'h0000, 1'b1, "ovf_min_sq"});
      tbl.push_back('{16'h8000, 16'hF000, 16'h8000, 1'b1, "ovf_min_xneg1"});
`endif

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_val", val, 0);
      @(negedge clk);
      i_rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[k]) begin
         run_op(tbl[k].a, tbl[k].b, v, o, cnt);
         chk({tbl[k].nm, "_latency"}, cnt, 18);
         chk({tbl[k].nm, "_val"}, v, tbl[k].v);
         chk({tbl[k].nm, "_ovf"}, o, tbl[k].o);
      end

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 2))
            0: begin
               ra = 16'($urandom);
               rb = 16'($urandom);
            end
            1: begin
               ra = 16'($urandom_range(0, 40));
               rb = $urandom_range(0, 1) ? 16'h0800 : 16'hF800;
            end
            default: begin
               ra = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
               rb = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
            end
         endcase
         model(ra, rb, ev, eo);
         run_op(ra, rb, v, o, cnt);
         chk("rand_latency", cnt, 18);
         chk("rand_val", v, ev);
         chk("rand_ovf", o, eo);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("hold_val", val, ev);
      chk("hold_ovf", ovf, eo);
      chk("hold_done_low", done, 0);

      // start during CALC with different operands must be ignored
      a = 16'h1800;
      b = 16'h2000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      a = 16'h3000;
      b = 16'h3000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ign_busy", busy, 1);
      wait_done(cnt);
      chk("ign_latency", cnt, 13);
      chk("ign_val", val, 16'h3000);
      chk("ign_ovf", ovf, 0);
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("ign_no_queue", seen, 0);

      // reset mid-CALC after an op that left ovf=1 and val nonzero
      run_op(16'h3000, 16'h3000, v, o, cnt);
      chk("pre_rst_ovf", o, 1);
      a = 16'h1800;
      b = 16'h2000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_val", val, 0);
      #3;
      i_rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      chk("mid_rst_no_done", seen, 0);
      run_op(16'hE800, 16'h2000, v, o, cnt);
      chk("post_rst_latency", cnt, 18);
      chk("post_rst_val", v, 16'hD000);
      chk("post_rst_ovf", o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
